// File: rtl/main_fsm.sv
// main_fsm: multicycle control state machine for the RV32I core.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives datapath mux selects and write strobes (Moore outputs, except
// the FETCH ir_write/pc_update strobes, which are qualified by memory ready).
//
// Parameters:
//   MEM_WAIT_EN   1: FETCH/MEMREAD/MEMWRITE wait for i_mem_ready
//                 0: i_mem_ready treated as constant 1
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_op             opcode from instruction register
//   i_mem_ready      memory completes current request this cycle
//   o_mem_req        memory request
//   o_pc_update      unconditional PC write enable
//   o_branch         branch state (PC write qualified externally)
//   o_adr_src        memory address select: 0 PC, 1 ALU result register
//   o_mem_write      data memory write
//   o_ir_write       instruction register / old-PC register write
//   o_reg_write      register file write
//   o_result_src     00 ALU result reg, 01 memory data, 10 ALU output
//   o_alu_src_a      00 PC, 01 old PC, 10 rs1, 11 zero
//   o_alu_src_b      00 rs2, 01 immediate, 10 constant 4
//   o_alu_op         00 ADD, 01 SUB, 10 decode funct
//   o_illegal_instr  unsupported opcode seen in DECODE
//   o_fsm_state      current state encoding (debug)
module main_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_pc_update,
    output logic       o_branch,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_illegal_instr,
    output logic [3:0] o_fsm_state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StLui      = 4'd12
    } state_e;

    state_e state_q, state_d;
    state_e decode_tgt;
    logic   op_legal;
    logic   ready;

    assign ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;

    // Opcode decode used by DECODE for both the branch target and illegal flag.
    always_comb begin
        decode_tgt = StFetch;
        op_legal   = 1'b1;
        case (i_op)
            7'b0000011,
            7'b0100011: decode_tgt = StMemAdr;
            7'b0110011: decode_tgt = StExecuteR;
            7'b0010011: decode_tgt = StExecuteI;
            7'b1100011: decode_tgt = StBranch;
            7'b1101111: decode_tgt = StJal;
            7'b1100111: decode_tgt = StJalr;
            7'b0110111: decode_tgt = StLui;
            7'b0010111: decode_tgt = StAluWb;
            default: begin
                decode_tgt = StFetch;
                op_legal   = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = ready ? StDecode : StFetch;
            StDecode:   state_d = decode_tgt;
            StMemAdr:   state_d = i_op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = ready ? StFetch : StMemWrite;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StJal;
            StLui:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; reset forces FETCH selects with every strobe low.
    always_comb begin
        o_mem_req       = 1'b0;
        o_pc_update     = 1'b0;
        o_branch        = 1'b0;
        o_adr_src       = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_result_src    = 2'b00;
        o_alu_src_a     = 2'b00;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_illegal_instr = 1'b0;
        o_fsm_state     = 4'd0;
        if (i_rst) begin
            o_alu_src_b  = 2'b10;
            o_result_src = 2'b10;
        end else begin
            o_fsm_state = state_q;
            case (state_q)
                StFetch: begin
                    o_mem_req    = 1'b1;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b10;
                    o_ir_write   = ready;
                    o_pc_update  = ready;
                end
                StDecode: begin
                    // Precompute oldPC + imm for branch/jal targets.
                    o_alu_src_a     = 2'b01;
                    o_alu_src_b     = 2'b01;
                    o_illegal_instr = ~op_legal;
                end
                StMemAdr: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                end
                StMemRead: begin
                    o_mem_req = 1'b1;
                    o_adr_src = 1'b1;
                end
                StMemWb: begin
                    o_result_src = 2'b01;
                    o_reg_write  = 1'b1;
                end
                StMemWrite: begin
                    o_mem_req   = 1'b1;
                    o_adr_src   = 1'b1;
                    o_mem_write = 1'b1;
                end
                StExecuteR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_op    = 2'b10;
                end
                StExecuteI: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    o_alu_op    = 2'b10;
                end
                StAluWb: begin
                    o_reg_write = 1'b1;
                end
                StBranch: begin
                    o_alu_src_a = 2'b10;
                    o_alu_op    = 2'b01;
                    o_branch    = 1'b1;
                end
                StJal: begin
                    // PC takes the target; ALU forms the link value oldPC + 4.
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b10;
                    o_pc_update = 1'b1;
                end
                StJalr: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                end
                StLui: begin
                    o_alu_src_a = 2'b11;
                    o_alu_src_b = 2'b01;
                end
                default: begin
                    o_fsm_state = state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each instruction is expanded into its
// sequence of phases from the per-instruction paths, every cycle's expected
// output bundle is queued by the driver and checked by a negedge monitor.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req, pc_update, branch, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal;
    logic [3:0] fsm_state;

    always #5 clk = ~clk;

    main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_op           (op),
        .i_mem_ready    (mem_ready),
        .o_mem_req      (mem_req),
        .o_pc_update    (pc_update),
        .o_branch       (branch),
        .o_adr_src      (adr_src),
        .o_mem_write    (mem_write),
        .o_ir_write     (ir_write),
        .o_reg_write    (reg_write),
        .o_result_src   (result_src),
        .o_alu_src_a    (alu_src_a),
        .o_alu_src_b    (alu_src_b),
        .o_alu_op       (alu_op),
        .o_illegal_instr(illegal),
        .o_fsm_state    (fsm_state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
    } exp_t;

    // Phase numbers are the documented state codes.
    localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5, PER = 6,
                   PEI = 7, PWB = 8, PBR = 9, PJAL = 10, PJALR = 11, PLUI = 12;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    exp_t mon_e, mon_a;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {fsm_state, mem_req, pc_update, branch, adr_src, mem_write, ir_write,
                     reg_write, illegal, result_src, alu_src_a, alu_src_b, alu_op};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL cycle_outputs vec=%0d op=%b rst=%b rdy=%b: got %h required %h",
                         n_vec, op, rst, mem_ready, mon_a, mon_e);
            end
        end
    end

    function automatic bit is_legal(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t rst_exp();
        exp_t e = '0;
        e.src_b      = 2'b10;
        e.result_src = 2'b10;
        return e;
    endfunction

    function automatic exp_t phase_exp(input int ph, input logic rdy, input bit ill);
        exp_t e = '0;
        e.st = 4'(ph);
        case (ph)
            PF:    begin e.mem_req = 1; e.src_b = 2'b10; e.result_src = 2'b10;
                         e.ir_write = rdy; e.pc_update = rdy; end
            PD:    begin e.src_a = 2'b01; e.src_b = 2'b01; e.illegal = ill; end
            PMA:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
            PMR:   begin e.mem_req = 1; e.adr_src = 1; end
            PMWB:  begin e.result_src = 2'b01; e.reg_write = 1; end
            PMW:   begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
            PER:   begin e.src_a = 2'b10; e.alu_op = 2'b10; end
            PEI:   begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
            PWB:   begin e.reg_write = 1; end
            PBR:   begin e.src_a = 2'b10; e.alu_op = 2'b01; e.branch = 1; end
            PJAL:  begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_update = 1; end
            PJALR: begin e.src_a = 2'b10; e.src_b = 2'b01; end
            PLUI:  begin e.src_a = 2'b11; e.src_b = 2'b01; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic drive(input logic r, input logic [6:0] o, input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        rst       = r;
        op        = o;
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    // Run one instruction; fw/mw are wait cycles in FETCH and the memory
    // state. If rst_at indexes a cycle of the instruction, reset is held there
    // for rst_len cycles and the instruction is abandoned.
    task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                             input int rst_at, input int rst_len);
        int   path[$];
        int   ph_q[$];
        logic rdy_q[$];
        bit   ill = !is_legal(o);
        case (o)
            7'b0000011: path = '{PF, PD, PMA, PMR, PMWB};
            7'b0100011: path = '{PF, PD, PMA, PMW};
            7'b0110011: path = '{PF, PD, PER, PWB};
            7'b0010011: path = '{PF, PD, PEI, PWB};
            7'b0010111: path = '{PF, PD, PWB};
            7'b0110111: path = '{PF, PD, PLUI, PWB};
            7'b1100011: path = '{PF, PD, PBR};
            7'b1101111: path = '{PF, PD, PJAL, PWB};
            7'b1100111: path = '{PF, PD, PJALR, PJAL, PWB};
            default:    path = '{PF, PD};
        endcase
        foreach (path[k]) begin
            if (path[k] == PF || path[k] == PMR || path[k] == PMW) begin
                for (int w = 0; w < ((path[k] == PF) ? fw : mw); w++) begin
                    ph_q.push_back(path[k]);
                    rdy_q.push_back(1'b0);
                end
                ph_q.push_back(path[k]);
                rdy_q.push_back(1'b1);
            end else begin
                ph_q.push_back(path[k]);
                rdy_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        foreach (ph_q[i]) begin
            if (i == rst_at) begin
                for (int r = 0; r < rst_len; r++) begin
                    drive(1'b1, o, 1'($urandom_range(0, 1)), rst_exp());
                end
                return;
            end
            drive(1'b0, o, rdy_q[i], phase_exp(ph_q[i], rdy_q[i], ill));
        end
    endtask

    logic [6:0] legal_ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111};

    initial begin
        logic [6:0] rop;
        int         rst_at;
        rst       = 1'b1;
        op        = 7'd0;
        mem_ready = 1'b0;
        drive(1'b1, 7'd0, 1'b0, rst_exp());
        drive(1'b1, 7'd0, 1'b1, rst_exp());

        // Directed sequences
        run_instr(7'b0110011, 0, 0, -1, 0);  // R-type: 0,1,6,8
        run_instr(7'b0000011, 2, 3, -1, 0);  // lw with waits
        run_instr(7'b0100011, 0, 0, -1, 0);  // sw
        run_instr(7'b1100011, 0, 0, -1, 0);  // branch
        run_instr(7'b1100111, 0, 0, -1, 0);  // jalr
        run_instr(7'b0000000, 0, 0, -1, 0);  // illegal
        run_instr(7'b0100011, 0, 3, 3, 2);   // reset in MEMWRITE while waiting
        run_instr(7'b0110111, 1, 0, -1, 0);  // lui
        run_instr(7'b0010111, 0, 0, -1, 0);  // auipc
        run_instr(7'b1101111, 0, 0, 0, 1);   // reset coinciding with FETCH ready
        run_instr(7'b1101111, 0, 0, -1, 0);  // jal

        // Randomized instructions
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) != 0) begin
                rop = legal_ops[$urandom_range(0, 8)];
            end else begin
                rop = 7'($urandom);
                for (int t = 0; t < 16 && is_legal(rop); t++) rop = 7'($urandom);
                if (is_legal(rop)) rop = 7'b1111111;
            end
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_instr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      rst_at, int'($urandom_range(1, 2)));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
